time_display: RTL
=================

TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SHALL have parameter P_HOUR_BIT, default 5, width of hour input.
REQ-002 SHALL have parameter P_MIN_BIT, default 6, width of min and sec inputs.
REQ-003 SHALL have parameter P_SCAN_DIV, default 100000, clk cycles per digit scan slot.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port hour  input  P_HOUR_BIT  binary hour from the hour counter.
REQ-007 SHALL have port min  input  P_MIN_BIT  binary minute.
REQ-008 SHALL have port sec  input  P_MIN_BIT  binary second.
REQ-009 SHALL have port seg  output  7  active-low segments, seg[6:0] = {a,b,c,d,e,f,g}, registered.
REQ-010 SHALL have port an  output  6  active-low one-hot digit enable, registered.
REQ-011 SHALL have port dp  output  1  active-low decimal point, registered.
REQ-012 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-013 SHALL hold snapshot registers for hour/min/sec and six 4-bit BCD digit registers: d0 = sec ones … d5 = hour tens.
REQ-014 SHALL run FSM states IDLE, SHIFT, DONE.
REQ-015 In IDLE, if {hour,min,sec} differs from the snapshot, SHALL load the snapshot, clear the BCD scratch, and go to SHIFT in the same edge.
REQ-016 SHIFT SHALL last exactly 6 cycles, one double-dabble step per cycle on all three fields in parallel: add 3 to any scratch nibble >= 5, then shift left one bit.
REQ-017 Hour SHALL be zero-extended to 6 bits before conversion.
REQ-018 DONE SHALL last 1 cycle, SHALL write d0..d5 atomically, then return to IDLE.
REQ-019 Latency SHALL be fixed: input change sampled at edge N -> new digits in d0..d5 after edge N+7 and visible on seg from edge N+8 when the digit is scanned.
REQ-020 Input changes during SHIFT/DONE SHALL be ignored. They are detected on the first IDLE cycle after DONE, so the last value always wins.
REQ-021 Values SHALL be displayed unclamped: hour up to 31 and min/sec up to 63 convert correctly, with no error indication.
REQ-022 busy SHALL be high exactly in SHIFT and DONE.
REQ-023 Prescaler SHALL count 0..P_SCAN_DIV-1 and wrap. On wrap the digit index SHALL advance 0..5 and wrap to 0.
REQ-024 an SHALL equal ~(1 << index). seg SHALL be the decode of d[index], registered one cycle after the index changes.
REQ-025 Decode SHALL be 0-9 standard patterns, and 10-15 blank (7'b1111111).
REQ-026 dp SHALL be low (lit) when index is 2 or 4 (HH.MM.SS separators), high otherwise.
REQ-027 Scanning SHALL continue independently of the FSM. A digit update in DONE SHALL never produce mixed old/new digit values.

Reset
REQ-028 reset SHALL be sampled on the clk edge only, with priority over all other activity, including mid-SHIFT abort.
REQ-029 Reset values SHALL be: FSM IDLE, snapshot 0, d0..d5 0, prescaler 0, index 0, an 6'b111110, seg 7'b0000001, dp 1, busy 0.
REQ-030 After reset, non-zero inputs SHALL start a conversion on the first cycle following reset deassertion.

Structure
REQ-031 FSM state encodings, segment pattern constants, and digit count (6) SHALL live in the shared clock package/include used by the clock blocks.
REQ-032 BCD-to-segment decode SHALL be a combinational sub-module seg7_decode, instantiated once on the muxed digit.
REQ-033 No other sub-modules SHALL be used. Parameters SHALL be passed down from the clock top level.

Verification (P_SCAN_DIV = 4 in bench)
REQ-034 Bench SHALL cover: reset, inputs 0 -> busy stays 0; an=111110, seg=0000001 ("0"), dp=1.
REQ-035 Bench SHALL cover: hour=23, min=59, sec=58 applied at edge N -> busy 1 for cycles N+1..N+7, then digits {2,3,5,9,5,8}; at index 5 seg=0010010 ("2"), at index 2 dp=0.
REQ-036 Bench SHALL cover: sec 58->59 while busy -> first conversion completes with 58, a second conversion follows immediately, and the final d0=9.
REQ-037 Bench SHALL cover: reset at 3rd SHIFT cycle -> next cycle FSM IDLE, all digits 0, busy 0. Held inputs 12:34:56 then reconvert, giving {1,2,3,4,5,6}.
REQ-038 Bench SHALL cover: scan over 24 cycles -> an sequence 111110,111101,…,011111, each held 4 cycles, then wraps to 111110.
REQ-039 Bench SHALL cover: hour=31, sec=63 (out of range) -> digits d5,d4=3,1 and d1,d0=6,3, no blanking.

Source files
------------

// File: rtl/time_display_pkg.sv
// Shared definitions for the clock display blocks: FSM encodings, segment
// patterns, digit count and the double-dabble step helper.
package time_display_pkg;

    localparam int NUM_DIGITS   = 6;
    localparam int CONV_BITS    = 6;
    localparam int SHIFT_CYCLES = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_t;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // One double-dabble step on {tens[13:10], ones[9:6], binary[5:0]}:
    // add 3 to any BCD nibble >= 5, then shift the whole word left by one.
    function automatic logic [13:0] dd_step(input logic [13:0] v);
        logic [13:0] t;
        t = v;
        if (t[13:10] >= 4'd5) begin
            t[13:10] = t[13:10] + 4'd3;
        end else begin
            t[13:10] = t[13:10];
        end
        if (t[9:6] >= 4'd5) begin
            t[9:6] = t[9:6] + 4'd3;
        end else begin
            t[9:6] = t[9:6];
        end
        return {t[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/time_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10..15 are blanked.
module seg7_decode
    import time_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_display.sv
// HH.MM.SS six-digit multiplexed display driver. A snapshot of the binary
// time is converted to BCD by a fixed-length double-dabble FSM, committed to
// the digit registers in one edge, and scanned out independently.
module time_display
    import time_display_pkg::*;
#(
    parameter int P_HOUR_BIT = 5,
    parameter int P_MIN_BIT  = 6,
    parameter int P_SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [P_HOUR_BIT-1:0] hour,
    input  logic [P_MIN_BIT-1:0]  min,
    input  logic [P_MIN_BIT-1:0]  sec,
    output logic [6:0]            seg,
    output logic [5:0]            an,
    output logic                  dp,
    output logic                  busy
);

    localparam int PRESC_W = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(P_SCAN_DIV - 1);

    fsm_state_t                       state_r;
    fsm_state_t                       state_nxt_s;
    logic                             load_s;
    logic                             step_s;
    logic                             commit_s;
    logic                             change_s;

    logic [P_HOUR_BIT-1:0]            hour_snap_r;
    logic [P_MIN_BIT-1:0]             min_snap_r;
    logic [P_MIN_BIT-1:0]             sec_snap_r;
    logic [13:0]                      hour_work_r;
    logic [13:0]                      min_work_r;
    logic [13:0]                      sec_work_r;
    logic [2:0]                       step_cnt_r;
    logic [NUM_DIGITS-1:0][3:0]       digits_r;
    logic                             busy_r;

    logic [PRESC_W-1:0]               presc_r;
    logic [2:0]                       index_r;
    logic [3:0]                       digit_mux_s;
    logic [6:0]                       seg_dec_s;
    logic [6:0]                       seg_r;
    logic [5:0]                       an_r;
    logic                             dp_r;

    assign change_s = ({hour, min, sec} != {hour_snap_r, min_snap_r, sec_snap_r});

    // Next-state and control strobes for the conversion FSM
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (change_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                step_s = 1'b1;
                if (step_cnt_r == 3'(SHIFT_CYCLES - 1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                commit_s    = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register and busy flag (busy tracks SHIFT/DONE exactly)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Snapshot capture and parallel double-dabble scratch for all three fields
    always_ff @(posedge clk) begin
        if (reset) begin
            hour_snap_r <= '0;
            min_snap_r  <= '0;
            sec_snap_r  <= '0;
            hour_work_r <= 14'd0;
            min_work_r  <= 14'd0;
            sec_work_r  <= 14'd0;
            step_cnt_r  <= 3'd0;
        end else if (load_s) begin
            hour_snap_r <= hour;
            min_snap_r  <= min;
            sec_snap_r  <= sec;
            hour_work_r <= {8'd0, CONV_BITS'(hour)};
            min_work_r  <= {8'd0, CONV_BITS'(min)};
            sec_work_r  <= {8'd0, CONV_BITS'(sec)};
            step_cnt_r  <= 3'd0;
        end else if (step_s) begin
            hour_work_r <= dd_step(hour_work_r);
            min_work_r  <= dd_step(min_work_r);
            sec_work_r  <= dd_step(sec_work_r);
            step_cnt_r  <= step_cnt_r + 3'd1;
        end else begin
            step_cnt_r  <= step_cnt_r;
        end
    end

    // Atomic commit of all six digits so the scan never sees a mixed value
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_r <= '0;
        end else if (commit_s) begin
            digits_r <= {hour_work_r[13:10], hour_work_r[9:6],
                         min_work_r[13:10],  min_work_r[9:6],
                         sec_work_r[13:10],  sec_work_r[9:6]};
        end else begin
            digits_r <= digits_r;
        end
    end

    // Scan prescaler and digit index, free running regardless of the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
            index_r <= 3'd0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
            if (index_r == 3'(NUM_DIGITS - 1)) begin
                index_r <= 3'd0;
            end else begin
                index_r <= index_r + 3'd1;
            end
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Select the digit currently being scanned
    always_comb begin
        digit_mux_s = 4'd0;
        case (index_r)
            3'd0:    digit_mux_s = digits_r[0];
            3'd1:    digit_mux_s = digits_r[1];
            3'd2:    digit_mux_s = digits_r[2];
            3'd3:    digit_mux_s = digits_r[3];
            3'd4:    digit_mux_s = digits_r[4];
            3'd5:    digit_mux_s = digits_r[5];
            default: digit_mux_s = 4'd0;
        endcase
    end

    seg7_decode u_seg7_decode (
        .digit (digit_mux_s),
        .seg   (seg_dec_s)
    );

    // Registered display drive; an/seg/dp all derive from the same index
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r <= SEG_0;
            an_r  <= 6'b111110;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= seg_dec_s;
            an_r  <= ~(6'd1 << index_r);
            dp_r  <= !((index_r == 3'd2) || (index_r == 3'd4));
        end
    end

    assign seg  = seg_r;
    assign an   = an_r;
    assign dp   = dp_r;
    assign busy = busy_r;

endmodule
